// File: rtl/lut_pkg.sv
// Shared constants, FSM state type and reset contents for the 3BC target-table loader.
package lut_pkg;

  localparam int LUT_DEPTH = 16;
  localparam int LUT_W     = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } lut_ld_state_t;

  // Entry 0 is -402 (10'h26E); every other entry defaults to +1. Index 0 is the lowest slice.
  localparam logic [LUT_DEPTH-1:0][LUT_W-1:0] LUT_DEFAULTS = {{(LUT_DEPTH-1){10'h001}}, 10'h26E};

endpackage

// File: rtl/lut_store.sv
// DEPTH x W register table: async reset to LUT_DEFAULTS, one sync write port, one combinational read port.
module lut_store
  import lut_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int W     = LUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] rd_vec [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry;

    // Entries beyond the packaged default table come up as zero.
    if (gi < LUT_DEPTH) begin : g_dflt
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry <= W'(LUT_DEFAULTS[gi]);
        else if (we && (waddr == AW'(gi)))
          entry <= wdata;
      end
    end else begin : g_zero
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry <= '0;
        else if (we && (waddr == AW'(gi)))
          entry <= wdata;
      end
    end

    assign rd_vec[gi] = entry;
  end

  assign rdata = rd_vec[raddr];

endmodule

// File: rtl/lut_loader.sv
// Sequential valid/ready loader for the branch-target table; read port is always live.
// Optional checksum beat after the last entry: define LUT_LOADER_CHECKSUM_EN.
module lut_loader
  import lut_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH,
  parameter int W     = LUT_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     LdValid,
  input  logic [W-1:0]             LdData,
  output logic                     LdReady,
  input  logic [$clog2(DEPTH)-1:0] Index,
  output logic [W-1:0]             Out,
  output logic                     Busy,
  output logic                     Loaded,
  output logic                     Err
);

  localparam int AW = $clog2(DEPTH);

  lut_ld_state_t state;
  logic [AW-1:0] count;
  logic          loaded;
  logic          we;
  logic          last_beat;
  logic          restart;

  assign LdReady   = (state == LOAD) || (state == CHECK);
  assign Busy      = LdReady;
  assign we        = (state == LOAD) && LdValid;
  assign last_beat = we && (count == AW'(DEPTH - 1));
  // Start is only honoured when no sequence is running.
  assign restart   = Start && ((state == IDLE) || (state == DONE));

  lut_store #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_store (
    .clk   (Clk),
    .rst   (Reset),
    .we    (we),
    .waddr (count),
    .wdata (LdData),
    .raddr (Index),
    .rdata (Out)
  );

`ifdef LUT_LOADER_CHECKSUM_EN
  logic [W-1:0] sum;
  logic         err;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      sum <= '0;
    else if (restart)
      sum <= '0;
    else if (we)
      sum <= sum + LdData;
  end

  assign Err = err;
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      count  <= '0;
      loaded <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (restart) begin
            state  <= LOAD;
            count  <= '0;
            loaded <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
            err    <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (we) begin
            count <= count + 1'b1;
            if (last_beat) begin
`ifdef LUT_LOADER_CHECKSUM_EN
              state  <= CHECK;
`else
              state  <= DONE;
              loaded <= 1'b1;
`endif
            end
          end
        end
        CHECK: begin
`ifdef LUT_LOADER_CHECKSUM_EN
          // The running sum already covers all entries; this beat carries the expected sum.
          if (LdValid) begin
            state <= DONE;
            if (sum == LdData)
              loaded <= 1'b1;
            else
              err <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Loaded = loaded;

endmodule

// File: tb/tb_lut_loader.sv
// Directed self-checking bench for lut_loader (checksum steps compile in with LUT_LOADER_CHECKSUM_EN).
module tb_lut_loader;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       LdValid = 1'b0;
  logic [9:0] LdData = '0;
  logic       LdReady;
  logic [3:0] Index = '0;
  logic [9:0] Out;
  logic       Busy;
  logic       Loaded;
  logic       Err;

  int n_assert = 0;
  int n_fail   = 0;

  lut_loader dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Start   (Start),
    .LdValid (LdValid),
    .LdData  (LdData),
    .LdReady (LdReady),
    .Index   (Index),
    .Out     (Out),
    .Busy    (Busy),
    .Loaded  (Loaded),
    .Err     (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic read_chk(input string tag, input int idx, input logic [9:0] exp);
    Index = 4'(idx);
    #1;
    check(tag, {22'd0, Out}, {22'd0, exp});
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic beat(input logic [9:0] d);
    LdValid = 1'b1;
    LdData  = d;
    @(negedge Clk);
    LdValid = 1'b0;
  endtask

  initial begin
    // Reset and default contents
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("rst_busy",   32'(Busy),    32'd0);
    check("rst_loaded", 32'(Loaded),  32'd0);
    check("rst_err",    32'(Err),     32'd0);
    check("rst_ready",  32'(LdReady), 32'd0);
    for (int i = 0; i < 16; i++)
      read_chk("rst_out", i, (i == 0) ? 10'h26E : 10'h001);

    // Back-to-back load of 10*i
    @(negedge Clk);
    pulse_start();
    #1;
    check("b2b_ready", 32'(LdReady), 32'd1);
    check("b2b_busy",  32'(Busy),    32'd1);
    for (int i = 0; i < 16; i++) beat(10'(10 * i));
    #1;
    check("b2b_loaded", 32'(Loaded), 32'd1);
    check("b2b_busy_n", 32'(Busy),   32'd0);
    check("b2b_ready_n", 32'(LdReady), 32'd0);
    check("b2b_err",    32'(Err),    32'd0);
    for (int i = 0; i < 16; i++) read_chk("b2b_out", i, 10'(10 * i));

    // Stalled load of 3*i+7 with a 3-cycle gap after beat 7
    @(negedge Clk);
    pulse_start();
    #1;
    check("stl_ld_clr", 32'(Loaded), 32'd0);
    for (int i = 0; i < 8; i++) beat(10'(3 * i + 7));
    for (int k = 0; k < 3; k++) begin
      read_chk("stl_idx9", 9, 10'd90);
      check("stl_busy", 32'(Busy), 32'd1);
      @(negedge Clk);
    end
    read_chk("stl_e7", 7, 10'd28);
    read_chk("stl_e8_old", 8, 10'd80);
    LdValid = 1'b1;
    LdData  = 10'd31;
    #1;
    check("stl_wr_old", {22'd0, Out}, 32'd80);
    @(negedge Clk);
    LdValid = 1'b0;
    #1;
    check("stl_wr_new", {22'd0, Out}, 32'd31);
    for (int i = 9; i < 16; i++) beat(10'(3 * i + 7));
    #1;
    check("stl_loaded", 32'(Loaded), 32'd1);
    read_chk("stl_e9", 9, 10'd34);
    read_chk("stl_e15", 15, 10'd52);

    // Start while busy is ignored, then reset mid-load
    @(negedge Clk);
    pulse_start();
    beat(10'd500);
    beat(10'd501);
    beat(10'd502);
    Start = 1'b1;
    beat(10'd503);
    Start = 1'b0;
    beat(10'd504);
    read_chk("mid_e0", 0, 10'd500);
    read_chk("mid_e4", 4, 10'd504);
    check("mid_busy", 32'(Busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("mid_async", {22'd0, Out}, 32'h001);
    check("mid_rbusy", 32'(Busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    read_chk("mid_def0", 0, 10'h26E);
    read_chk("mid_def3", 3, 10'h001);
    check("mid_loaded", 32'(Loaded), 32'd0);
    check("mid_ready",  32'(LdReady), 32'd0);

`ifdef LUT_LOADER_CHECKSUM_EN
    // Checksum match: sixteen 1s sum to 16
    @(negedge Clk);
    pulse_start();
    for (int i = 0; i < 16; i++) beat(10'h001);
    #1;
    check("ck_busy",   32'(Busy),    32'd1);
    check("ck_ready",  32'(LdReady), 32'd1);
    check("ck_pend",   32'(Loaded),  32'd0);
    beat(10'h010);
    #1;
    check("ck_loaded", 32'(Loaded), 32'd1);
    check("ck_err",    32'(Err),    32'd0);

    // Checksum mismatch
    @(negedge Clk);
    pulse_start();
    for (int i = 0; i < 16; i++) beat(10'h001);
    beat(10'h011);
    #1;
    check("ckm_err",    32'(Err),    32'd1);
    check("ckm_loaded", 32'(Loaded), 32'd0);
    read_chk("ckm_e0", 0, 10'h001);
    @(negedge Clk);
    pulse_start();
    #1;
    check("ckm_clr", 32'(Err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
